// File: rtl/wb_xbar_ctrl.sv
// wb_xbar_ctrl: single-master, NUM_SLAVES-port Wishbone-style crossbar controller.
// Decodes a slave index from the request address, presents a one-hot strobe,
// waits (with timeout) for the selected slave's ack and returns data/err to the master.
//
// Handshake: the master raises m_stb_i with m_we_i/m_addr_i/m_data_i and holds it
// until it sees m_ack_o or m_err_o (each a one-cycle registered pulse, never both).
// A slave completes by raising its s_ack_i bit while its s_stb_o bit is high; ack
// bits of other slaves, or acks seen while no strobe is presented, are ignored.
// A new request is taken in the IDLE cycle after the ack/err pulse.
module wb_xbar_ctrl #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int NUM_SLAVES = 8,
   parameter int IDX_LSB    = 28,
   parameter int TIMEOUT    = 255
) (
   input  logic                         clk,
   input  logic                         rst,
   // master side
   input  logic                         m_stb_i,
   input  logic                         m_we_i,
   input  logic [ADDR_W-1:0]            m_addr_i,
   input  logic [DATA_W-1:0]            m_data_i,
   output logic [DATA_W-1:0]            m_data_o,
   output logic                         m_ack_o,
   output logic                         m_err_o,
   // slave side
   output logic [NUM_SLAVES-1:0]        s_stb_o,
   output logic                         s_we_o,
   output logic [ADDR_W-1:0]            s_addr_o,
   output logic [DATA_W-1:0]            s_data_o,
   input  logic [NUM_SLAVES*DATA_W-1:0] s_data_i,
   input  logic [NUM_SLAVES-1:0]        s_ack_i,
   // status / debug
   output logic [7:0]                   err_cnt,
   output logic [1:0]                   dbg_state_o
);

   localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int CNT_W = 16;
   localparam logic [IDX_W:0]   NUM_S = (IDX_W+1)'(NUM_SLAVES);
   localparam logic [CNT_W-1:0] TMO   = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2,
      ERR  = 2'd3
   } state_t;

   state_t                  state_q;
   logic [IDX_W-1:0]        idx_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [NUM_SLAVES-1:0]   stb_q;
   logic                    we_q;
   logic [ADDR_W-1:0]       addr_q;
   logic [DATA_W-1:0]       wdata_q;
   logic [DATA_W-1:0]       rdata_q;
   logic                    ack_q;
   logic                    err_q;
   logic [7:0]              err_cnt_q;

   logic [IDX_W-1:0]        req_idx;
   logic                    req_ok;
   logic [NUM_SLAVES-1:0]   onehot;
   logic [DATA_W-1:0]       sel_data;
   logic                    sel_ack;

   // Decode the requested slave index, its one-hot strobe and the selected return path
   always_comb begin
      req_idx  = m_addr_i[IDX_LSB +: IDX_W];
      req_ok   = ({1'b0, req_idx} < NUM_S);
      onehot   = NUM_SLAVES'(1) << idx_q;
      sel_data = s_data_i[int'(idx_q)*DATA_W +: DATA_W];
      // stb_q is one-hot on the selected slave, so this masks both stray acks of
      // other slaves and any ack seen before the strobe is actually presented
      sel_ack  = |(s_ack_i & stb_q);
   end

   // Transaction FSM with registered master/slave outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         cnt_q     <= '0;
         stb_q     <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // the cycle carrying the ack/err pulse still sees the master's held
               // strobe for the finished request, so it is not a new request
               if (m_stb_i && !ack_q && !err_q) begin
                  addr_q  <= m_addr_i;
                  we_q    <= m_we_i;
                  wdata_q <= m_data_i;
                  idx_q   <= req_idx;
                  cnt_q   <= '0;
                  state_q <= req_ok ? BUSY : ERR;
               end
            end
            BUSY: begin
               if (stb_q == '0) begin
                  // first BUSY cycle: start presenting the strobe
                  stb_q <= onehot;
               end else if (sel_ack) begin
                  // ack wins over a simultaneous timeout
                  rdata_q <= sel_data;
                  stb_q   <= '0;
                  state_q <= RESP;
               end else if (cnt_q == TMO) begin
                  stb_q   <= '0;
                  state_q <= ERR;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RESP: begin
               ack_q   <= 1'b1;
               state_q <= IDLE;
            end
            ERR: begin
               err_q   <= 1'b1;
               rdata_q <= '0;
               if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign m_data_o    = rdata_q;
   assign m_ack_o     = ack_q;
   assign m_err_o     = err_q;
   assign s_stb_o     = stb_q;
   assign s_we_o      = we_q;
   assign s_addr_o    = addr_q;
   assign s_data_o    = wdata_q;
   assign err_cnt     = err_cnt_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_xbar_ctrl.sv
// Bench for wb_xbar_ctrl: table of transactions with expected strobe, response,
// latency and data; expected responses queued at drive time and popped on ack/err.
module tb_wb_xbar_ctrl;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int NS = 6;
   localparam int TO = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            m_stb_i;
   logic            m_we_i;
   logic [AW-1:0]   m_addr_i;
   logic [DW-1:0]   m_data_i;
   logic [DW-1:0]   m_data_o;
   logic            m_ack_o;
   logic            m_err_o;
   logic [NS-1:0]   s_stb_o;
   logic            s_we_o;
   logic [AW-1:0]   s_addr_o;
   logic [DW-1:0]   s_data_o;
   logic [NS*DW-1:0] s_data_i;
   logic [NS-1:0]   s_ack_i;
   logic [7:0]      err_cnt;
   logic [1:0]      dbg_state_o;

   int checks   = 0;
   int failures = 0;
   int exp_err_cnt = 0;

   // expected response: {err, response cycle index, data}
   logic [40:0] exp_q[$];

   typedef struct {
      logic          we;
      logic [31:0]   addr;
      logic [31:0]   wdata;
      int            ack_at;    // strobe cycle (1-based) on which slave acks; 0 = never
      logic [NS-1:0] stray;     // ack bits of other slaves raised while strobing
      logic [31:0]   rdata;     // selected slave's read data
      logic [NS-1:0] exp_stb;
      logic          exp_err;
      int            exp_lat;   // negedge index (1 = first after accept edge) of response
      int            exp_nstb;  // cycles with strobe high
      logic [31:0]   exp_data;
   } vec_t;

   vec_t vecs[9];

   wb_xbar_ctrl #(
      .DATA_W(DW), .ADDR_W(AW), .NUM_SLAVES(NS), .IDX_LSB(28), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_addr_i(m_addr_i), .m_data_i(m_data_i),
      .m_data_o(m_data_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
      .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_data_o(s_data_o),
      .s_data_i(s_data_i), .s_ack_i(s_ack_i),
      .err_cnt(err_cnt), .dbg_state_o(dbg_state_o)
   );

   // clock
   always #5 clk = ~clk;

   // watchdog
   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // drive one request, play the slave side, compare the response
   task automatic run_txn(input vec_t v);
      int nstb;
      logic done;
      logic [40:0] exp;
      logic [2:0]  sel;
      @(negedge clk);
      check("idle_no_pulse", {62'd0, m_ack_o, m_err_o}, 64'd0);
      sel = v.addr[30:28];
      for (int k = 0; k < NS; k++)
         s_data_i[k*DW +: DW] = (3'(k) == sel) ? v.rdata : (v.rdata ^ (32'h1111_1111 * (k + 1)));
      m_stb_i  = 1'b1;
      m_we_i   = v.we;
      m_addr_i = v.addr;
      m_data_i = v.wdata;
      if (v.exp_err) exp_err_cnt = (exp_err_cnt < 255) ? exp_err_cnt + 1 : 255;
      exp_q.push_back({v.exp_err, 8'(v.exp_lat), v.exp_data});
      nstb = 0;
      done = 1'b0;
      for (int c = 1; c <= 40 && !done; c++) begin
         @(negedge clk);
         if (c == 1) begin
            // request is registered; scramble master inputs to prove isolation
            m_addr_i = ~v.addr;
            m_data_i = ~v.wdata;
            m_we_i   = ~v.we;
         end
         s_ack_i = '0;
         if (m_ack_o && m_err_o) check("ack_err_exclusive", 64'd1, 64'd0);
         if (m_ack_o || m_err_o) begin
            exp = exp_q.pop_front();
            check("response", {23'd0, m_err_o, 8'(c), m_data_o}, {23'd0, exp});
            check("strobe_cycles", 64'(nstb), 64'(v.exp_nstb));
            check("err_cnt", {56'd0, err_cnt}, 64'(exp_err_cnt));
            m_stb_i = 1'b0;
            done = 1'b1;
         end else if (s_stb_o != '0) begin
            nstb++;
            check("s_stb_o", {58'd0, s_stb_o}, {58'd0, v.exp_stb});
            check("s_slave_bus", {s_we_o, s_addr_o, s_data_o}, {v.we, v.addr, v.wdata});
            s_ack_i = v.stray;
            if (nstb == v.ack_at) s_ack_i = s_ack_i | v.exp_stb;
         end
      end
      if (!done) begin
         check("response_wait", 64'd0, 64'd1);
         void'(exp_q.pop_front());
         m_stb_i = 1'b0;
      end
      s_ack_i = '0;
   endtask

   initial begin
      vecs[0] = '{we:1'b0, addr:32'h2000_0010, wdata:32'h0, ack_at:4, stray:6'h00, rdata:32'hDEAD_BEEF,
                  exp_stb:6'h04, exp_err:1'b0, exp_lat:7, exp_nstb:4, exp_data:32'hDEAD_BEEF};
      vecs[1] = '{we:1'b1, addr:32'h0000_0004, wdata:32'h1234_5678, ack_at:2, stray:6'h00, rdata:32'h0000_00A5,
                  exp_stb:6'h01, exp_err:1'b0, exp_lat:5, exp_nstb:2, exp_data:32'h0000_00A5};
      vecs[2] = '{we:1'b0, addr:32'h7000_0000, wdata:32'h0, ack_at:1, stray:6'h00, rdata:32'h7777_7777,
                  exp_stb:6'h00, exp_err:1'b1, exp_lat:2, exp_nstb:0, exp_data:32'h0};
      vecs[3] = '{we:1'b0, addr:32'h1000_0000, wdata:32'h0, ack_at:0, stray:6'h00, rdata:32'h1111_0000,
                  exp_stb:6'h02, exp_err:1'b1, exp_lat:8, exp_nstb:5, exp_data:32'h0};
      vecs[4] = '{we:1'b0, addr:32'h1000_0008, wdata:32'h0, ack_at:5, stray:6'h00, rdata:32'hCAFE_0001,
                  exp_stb:6'h02, exp_err:1'b0, exp_lat:8, exp_nstb:5, exp_data:32'hCAFE_0001};
      vecs[5] = '{we:1'b0, addr:32'h5000_0020, wdata:32'h0, ack_at:3, stray:6'h08, rdata:32'h5555_AAAA,
                  exp_stb:6'h20, exp_err:1'b0, exp_lat:6, exp_nstb:3, exp_data:32'h5555_AAAA};
      vecs[6] = '{we:1'b1, addr:32'h4000_0000, wdata:32'hA5A5_0F0F, ack_at:1, stray:6'h00, rdata:32'h0BAD_F00D,
                  exp_stb:6'h10, exp_err:1'b0, exp_lat:4, exp_nstb:1, exp_data:32'h0BAD_F00D};
      vecs[7] = '{we:1'b0, addr:32'h6FFF_FFFC, wdata:32'h0, ack_at:1, stray:6'h00, rdata:32'h6666_6666,
                  exp_stb:6'h00, exp_err:1'b1, exp_lat:2, exp_nstb:0, exp_data:32'h0};
      vecs[8] = '{we:1'b0, addr:32'h3000_0000, wdata:32'h0, ack_at:0, stray:6'h37, rdata:32'h3333_0003,
                  exp_stb:6'h08, exp_err:1'b1, exp_lat:8, exp_nstb:5, exp_data:32'h0};

      rst      = 1'b1;
      m_stb_i  = 1'b0;
      m_we_i   = 1'b0;
      m_addr_i = '0;
      m_data_i = '0;
      s_data_i = '0;
      s_ack_i  = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs",
            {m_data_o, m_ack_o, m_err_o, s_stb_o, s_we_o, err_cnt, dbg_state_o}, 64'd0);
      check("reset_slave_bus", {s_addr_o, s_data_o}, 64'd0);
      rst = 1'b0;

      // table of single transactions
      for (int i = 0; i < 9; i++) run_txn(vecs[i]);

      // random read data on slave 2, ack delay 1..4
      for (int i = 0; i < 6; i++) begin
         vec_t v;
         int d;
         v = vecs[0];
         d = $urandom_range(1, 4);
         v.rdata = $urandom;
         v.ack_at = d;
         v.exp_lat = d + 3;
         v.exp_nstb = d;
         v.exp_data = v.rdata;
         run_txn(v);
      end

      // reset while BUSY aborts the transaction, late ack is ignored
      @(negedge clk);
      m_stb_i = 1'b1; m_we_i = 1'b1; m_addr_i = 32'h1000_0040; m_data_i = 32'hFEED_F00D;
      repeat (3) @(negedge clk);
      check("abort_strobe", {58'd0, s_stb_o}, 64'h02);
      rst = 1'b1; m_stb_i = 1'b0;
      @(negedge clk);
      check("abort_outputs",
            {m_data_o, m_ack_o, m_err_o, s_stb_o, s_we_o, err_cnt, dbg_state_o}, 64'd0);
      check("abort_slave_bus", {s_addr_o, s_data_o}, 64'd0);
      rst = 1'b0;
      exp_err_cnt = 0;
      s_ack_i = 6'h02;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("abort_no_response", {61'd0, m_ack_o, m_err_o, |s_stb_o}, 64'd0);
      end
      s_ack_i = '0;

      // error counter saturation
      for (int i = 0; i < 300; i++) run_txn(vecs[2]);
      check("err_cnt_saturated", {56'd0, err_cnt}, 64'd255);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
